// File: rtl/systolic_spi_pkg.sv
// Shared definitions for the systolic accelerator SPI wrapper:
// controller state encoding, host command opcodes and default widths.
package systolic_spi_pkg;

    localparam int DEF_N      = 2;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CMD_DECODE = 3'd1,
        ST_LOAD_A     = 3'd2,
        ST_LOAD_B     = 3'd3,
        ST_COMPUTING  = 3'd4,
        ST_READ_C     = 3'd5,
        ST_STATUS     = 3'd6
    } state_t;

    localparam logic [7:0] CMD_LOAD_A = 8'h10;
    localparam logic [7:0] CMD_LOAD_B = 8'h20;
    localparam logic [7:0] CMD_START  = 8'h30;
    localparam logic [7:0] CMD_READ_C = 8'h40;
    localparam logic [7:0] CMD_STATUS = 8'h50;

endpackage

// File: rtl/systolic_spi_wrap_spi_slave.sv
// SPI mode-0 slave, byte oriented. All pins are brought into the clk domain
// through two-flop synchronizers; a third flop provides edge detection.
// rx_valid pulses one clk, three clk after the eighth sclk rising edge.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic [7:0] tx_data,
    output logic       miso,
    output logic       rx_valid,
    output logic [7:0] rx_data
);

    logic       sclk_p0, sclk_p1, sclk_p2;
    logic       mosi_p0, mosi_p1;
    logic       cs_p0, cs_p1, cs_p2;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic       sclk_rise, sclk_fall, cs_fall;

    // Synchronizer and edge-detect flops for the asynchronous SPI pins
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            cs_p0   <= cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = cs_p2 & ~cs_p1;

    // Shift engine: sample on rising sclk, present next bit on falling sclk;
    // deselect drops any partial byte
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            tx_sr    <= 8'd0;
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_p1) begin
                bit_cnt <= 3'd0;
            end else begin
                if (cs_fall) begin
                    tx_sr <= tx_data;
                end else if (sclk_fall) begin
                    // bit_cnt back at zero means a byte just completed
                    tx_sr <= (bit_cnt == 3'd0) ? tx_data : {tx_sr[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    rx_sr   <= {rx_sr[5:0], mosi_p1};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_valid <= 1'b1;
                        rx_data  <= {rx_sr, mosi_p1};
                    end
                end
            end
        end
    end

    assign miso = ~cs_n & tx_sr[7];

endmodule

// File: rtl/systolic_spi_wrap.sv
// Systolic accelerator top: SPI slave, command controller, A/B/C storage and
// a single sequential MAC computing C = A x B (one MAC per clk, k innermost).
// Optional feature macro: SYSTOLIC_SPI_IRQ_EN -- when undefined irq is tied 0
// and the host polls the STATUS command instead.
module systolic_spi_wrap
    import systolic_spi_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic miso,
    output logic irq
);

    localparam int NN         = N * N;
    localparam int AIW        = (NN > 1) ? $clog2(NN) : 1;
    localparam int KW         = (N > 1) ? $clog2(N) : 1;
    localparam int DBYTES     = DATA_W / 8;
    localparam int CBYTES     = ACC_W / 8;
    localparam int BW         = (CBYTES > 1) ? $clog2(CBYTES) : 1;
    localparam int LOAD_BYTES = NN * DBYTES;
    localparam int READ_BYTES = NN * CBYTES;
    localparam int CW         = $clog2(READ_BYTES + 1);
    localparam int PW         = 2 * DATA_W;
    localparam int SW         = ACC_W + PW;

`ifdef SYSTOLIC_SPI_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;

    state_t            state;
    logic [7:0]        cmd;
    logic [CW-1:0]     data_count;
    logic [AIW-1:0]    element_index;
    logic [BW-1:0]     byte_index;
    logic              done;
    logic              busy;
    logic              irq_r;

    logic signed [DATA_W-1:0] a_mem   [NN];
    logic signed [DATA_W-1:0] b_mem   [NN];
    logic signed [ACC_W-1:0]  c_mem   [NN];
    logic signed [ACC_W-1:0]  c_stage [NN];

    logic [KW-1:0]            mi, mj, mk;
    logic                     mac_fin;
    logic                     vld_p0;
    logic [AIW-1:0]           a_idx, b_idx, c_idx;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_p0;

    // Accumulate with two's-complement wrap modulo 2^ACC_W
    function automatic logic signed [ACC_W-1:0] wrap_acc(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [PW-1:0]    p
    );
        logic signed [SW-1:0] s;
        s = SW'(acc) + SW'(p);
        return $signed(s[ACC_W-1:0]);
    endfunction

    // Replace one little-endian byte of an A/B element
    function automatic logic signed [DATA_W-1:0] set_byte(
        input logic signed [DATA_W-1:0] w,
        input logic [BW-1:0]            sel,
        input logic [7:0]               b
    );
        logic signed [DATA_W-1:0] r;
        r = w;
        for (int n = 0; n < DBYTES; n++) begin
            if (sel == BW'(n)) r[n*8 +: 8] = b;
        end
        return r;
    endfunction

    // Extract one little-endian byte of a C element
    function automatic logic [7:0] get_byte(
        input logic signed [ACC_W-1:0] w,
        input logic [BW-1:0]           sel
    );
        logic [7:0] r;
        r = 8'h00;
        for (int n = 0; n < CBYTES; n++) begin
            if (sel == BW'(n)) r = w[n*8 +: 8];
        end
        return r;
    endfunction

    spi_slave spi_if (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .tx_data  (tx_data),
        .miso     (miso),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
    );

    assign busy   = (state == ST_COMPUTING);
    assign vld_p0 = busy & ~mac_fin;
    assign irq    = irq_r & IRQ_EN;

    // Response byte: C stream while reading, status word otherwise
    always_comb begin
        tx_data = {6'b0, done, busy};
        if (state == ST_READ_C) tx_data = get_byte(c_mem[element_index], byte_index);
    end

    // MAC operand selection and product / running sum
    always_comb begin
        a_idx    = AIW'(int'(mi) * N + int'(mk));
        b_idx    = AIW'(int'(mk) * N + int'(mj));
        c_idx    = AIW'(int'(mi) * N + int'(mj));
        prod     = PW'(a_mem[a_idx]) * PW'(b_mem[b_idx]);
        acc_base = (mk == '0) ? '0 : acc_p0;
        acc_next = wrap_acc(acc_base, prod);
    end

    // ---- MAC stage p0: running sum, finished dot products parked in c_stage
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            acc_p0 <= acc_next;
            if (mk == KW'(N - 1)) c_stage[c_idx] <= acc_next;
        end
    end

    // Command controller, storage writes and compute sequencing
    always_ff @(posedge clk) begin : spi_ctrl
        if (rst_n) begin
            state         <= ST_IDLE;
            cmd           <= 8'h00;
            data_count    <= '0;
            element_index <= '0;
            byte_index    <= '0;
            done          <= 1'b0;
            irq_r         <= 1'b0;
            mi            <= '0;
            mj            <= '0;
            mk            <= '0;
            mac_fin       <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
                c_mem[n] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        cmd   <= rx_data;
                        state <= ST_CMD_DECODE;
                    end
                end
                ST_CMD_DECODE: begin
                    data_count    <= '0;
                    element_index <= '0;
                    byte_index    <= '0;
                    mi            <= '0;
                    mj            <= '0;
                    mk            <= '0;
                    mac_fin       <= 1'b0;
                    case (cmd)
                        CMD_LOAD_A: state <= ST_LOAD_A;
                        CMD_LOAD_B: state <= ST_LOAD_B;
                        CMD_START: begin
                            state <= ST_COMPUTING;
                            done  <= 1'b0;
                        end
                        CMD_READ_C: state <= ST_READ_C;
                        CMD_STATUS: state <= ST_STATUS;
                        default:    state <= ST_IDLE;
                    endcase
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (rx_valid) begin
                        if (state == ST_LOAD_A)
                            a_mem[element_index] <= set_byte(a_mem[element_index], byte_index, rx_data);
                        else
                            b_mem[element_index] <= set_byte(b_mem[element_index], byte_index, rx_data);
                        data_count <= data_count + CW'(1);
                        if (byte_index == BW'(DBYTES - 1)) begin
                            byte_index    <= '0;
                            element_index <= element_index + AIW'(1);
                        end else begin
                            byte_index <= byte_index + BW'(1);
                        end
                        if (data_count == CW'(LOAD_BYTES - 1)) state <= ST_IDLE;
                    end
                end
                ST_COMPUTING: begin
                    // Incoming bytes are deliberately ignored here
                    if (mac_fin) begin
                        for (int n = 0; n < NN; n++) c_mem[n] <= c_stage[n];
                        done    <= 1'b1;
                        irq_r   <= 1'b1;
                        mac_fin <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        done <= 1'b0;
                        if (mk == KW'(N - 1)) begin
                            mk <= '0;
                            if (mj == KW'(N - 1)) begin
                                mj <= '0;
                                if (mi == KW'(N - 1)) begin
                                    mi      <= '0;
                                    mac_fin <= 1'b1;
                                end else begin
                                    mi <= mi + KW'(1);
                                end
                            end else begin
                                mj <= mj + KW'(1);
                            end
                        end else begin
                            mk <= mk + KW'(1);
                        end
                    end
                end
                ST_READ_C: begin
                    if (rx_valid) begin
                        data_count <= data_count + CW'(1);
                        if (byte_index == BW'(CBYTES - 1)) begin
                            byte_index    <= '0;
                            element_index <= element_index + AIW'(1);
                        end else begin
                            byte_index <= byte_index + BW'(1);
                        end
                        if (data_count == CW'(READ_BYTES - 1)) begin
                            state <= ST_IDLE;
                            irq_r <= 1'b0;
                        end
                    end
                end
                ST_STATUS: begin
                    if (rx_valid) begin
                        state <= ST_IDLE;
                        irq_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_spi_wrap.sv
// Bench for systolic_spi_wrap: drives SPI mode-0 frames from the host side,
// keeps A/B as plain integer matrices and computes C with ordinary arithmetic.
// Honours SYSTOLIC_SPI_IRQ_EN for the expected irq pin level.
module tb_systolic_spi_wrap;

    localparam int N  = 2;
    localparam int NN = N * N;
    localparam int HP = 6;

`ifdef SYSTOLIC_SPI_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk, rst_n, sclk, mosi, cs_n;
    logic miso, irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] txb [0:31];
    logic [7:0] rxb [0:31];
    logic signed [15:0] a_ref [NN];
    logic signed [15:0] b_ref [NN];

    int cyc = 0;
    int prev_state = 0;
    logic prev_irq = 1'b0;
    int t_comp_last = -1;
    int t_irq_last = -1;
    int t_dec_last = -1;

    systolic_spi_wrap #(.N(N), .DATA_W(16), .ACC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .mosi  (mosi),
        .cs_n  (cs_n),
        .miso  (miso),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event timestamps for latency and decode observations
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (int'(dut.state) == 4 && prev_state != 4) t_comp_last = cyc;
        if (int'(dut.state) == 1) t_dec_last = cyc;
        if (dut.irq_r && !prev_irq) t_irq_last = cyc;
        prev_state = int'(dut.state);
        prev_irq = dut.irq_r;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b > 7 - nbits; b--) begin
            mosi = tx[b];
            repeat (HP) @(negedge clk);
            rx[b] = miso;
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int n);
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < n; i++) spi_bits(txb[i], 8, rxb[i]);
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic load_mat(input logic [7:0] cmd, input bit is_b, input bit with_cmd);
        int p;
        logic [15:0] v;
        p = 0;
        if (with_cmd) begin
            txb[0] = cmd;
            p = 1;
        end
        for (int e = 0; e < NN; e++) begin
            v = is_b ? b_ref[e] : a_ref[e];
            txb[p] = v[7:0];
            txb[p+1] = v[15:8];
            p += 2;
        end
        frame(p);
    endtask

    task automatic compute();
        txb[0] = 8'h30;
        frame(1);
        chk("irq_after_compute", 64'(irq), 64'(IRQ_EN));
    endtask

    task automatic read_c();
        longint s;
        logic [31:0] exp_c;
        logic [31:0] got;
        txb[0] = 8'h40;
        for (int i = 1; i <= 16; i++) txb[i] = 8'($urandom);
        frame(17);
        for (int e = 0; e < NN; e++) begin
            s = 0;
            for (int k = 0; k < N; k++)
                s += longint'(a_ref[(e / N) * N + k]) * longint'(b_ref[k * N + (e % N)]);
            exp_c = s[31:0];
            got = {rxb[4*e+4], rxb[4*e+3], rxb[4*e+2], rxb[4*e+1]};
            chk($sformatf("c%0d", e), 64'(got), 64'(exp_c));
        end
        chk("irq_after_read", 64'(irq), 64'(0));
    endtask

    initial begin
        int t0;
        logic [7:0] junk;
        rst_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        chk("rst_miso", 64'(miso), 64'(0));
        chk("rst_irq", 64'(irq), 64'(0));
        chk("rst_state", 64'(int'(dut.state)), 64'(0));
        chk("rst_count", 64'(dut.data_count), 64'(0));
        chk("rst_done", 64'(dut.done), 64'(0));

        // Command in its own frame, first element in the next
        txb[0] = 8'h10;
        frame(1);
        chk("loada_state", 64'(int'(dut.state)), 64'(2));
        chk("loada_count", 64'(dut.data_count), 64'(0));
        txb[0] = 8'h01;
        txb[1] = 8'h00;
        frame(2);
        chk("a0_value", 64'($unsigned(dut.a_mem[0])), 64'(1));
        chk("elem_index", 64'(dut.element_index), 64'(1));
        chk("byte_index", 64'(dut.byte_index), 64'(0));
        a_ref[0] = 16'sd1; a_ref[1] = 16'sd2; a_ref[2] = 16'sd3; a_ref[3] = 16'sd4;
        for (int e = 1; e < NN; e++) begin
            txb[2*e-2] = a_ref[e][7:0];
            txb[2*e-1] = a_ref[e][15:8];
        end
        frame(6);
        chk("loada_done_state", 64'(int'(dut.state)), 64'(0));
        b_ref[0] = 16'sd5; b_ref[1] = 16'sd6; b_ref[2] = 16'sd7; b_ref[3] = 16'sd8;
        load_mat(8'h20, 1'b1, 1'b1);

        // Start then status: the byte shifted during 0x50 reflects busy
        t0 = cyc;
        txb[0] = 8'h30;
        txb[1] = 8'h50;
        frame(2);
        chk("status_busy", 64'(rxb[1]), 64'(8'h01));
        chk("compute_latency",
            64'((t_comp_last > t0 && t_irq_last > t_comp_last) ? t_irq_last - t_comp_last : -1),
            64'(N * N * N + 1));
        chk("irq_pin_set", 64'(irq), 64'(IRQ_EN));
        txb[0] = 8'h00;
        frame(1);
        chk("status_done", 64'(rxb[0]), 64'(8'h02));
        chk("irq_status_clr", 64'(irq), 64'(0));
        compute();
        read_c();

        // All -1 times all 2
        for (int e = 0; e < NN; e++) begin
            a_ref[e] = -16'sd1;
            b_ref[e] = 16'sd2;
        end
        load_mat(8'h10, 1'b0, 1'b1);
        load_mat(8'h20, 1'b1, 1'b1);
        compute();
        read_c();

        // Partial byte dropped by deselect, then a clean LOAD_B command
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        spi_bits(8'h10, 5, junk);
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (HP) @(negedge clk);
        chk("abort_idle", 64'(int'(dut.state)), 64'(0));
        txb[0] = 8'h20;
        frame(1);
        chk("abort_loadb", 64'(int'(dut.state)), 64'(3));
        for (int e = 0; e < NN; e++) b_ref[e] = 16'($urandom);
        load_mat(8'h00, 1'b1, 1'b0);
        compute();
        read_c();

        // Random matrices
        for (int it = 0; it < 2; it++) begin
            for (int e = 0; e < NN; e++) begin
                a_ref[e] = 16'($urandom);
                b_ref[e] = 16'($urandom);
            end
            load_mat(8'h10, 1'b0, 1'b1);
            load_mat(8'h20, 1'b1, 1'b1);
            compute();
            read_c();
        end

        // Unknown opcode leaves everything untouched
        t0 = cyc;
        txb[0] = 8'h77;
        frame(1);
        chk("unk_decode_seen", 64'(t_dec_last > t0), 64'(1));
        chk("unk_state", 64'(int'(dut.state)), 64'(0));
        chk("unk_a0", 64'($unsigned(dut.a_mem[0])), 64'($unsigned(a_ref[0])));
        read_c();

        // Reset during LOAD_A clears storage and returns to IDLE
        txb[0] = 8'h10;
        txb[1] = 8'h34;
        frame(2);
        chk("pre_rst_state", 64'(int'(dut.state)), 64'(2));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_state", 64'(int'(dut.state)), 64'(0));
        chk("post_rst_a0", 64'($unsigned(dut.a_mem[0])), 64'(0));
        chk("post_rst_count", 64'(dut.data_count), 64'(0));
        for (int e = 0; e < NN; e++) begin
            a_ref[e] = 16'sd0;
            b_ref[e] = 16'sd0;
        end
        read_c();
        txb[0] = 8'h50;
        txb[1] = 8'h00;
        frame(2);
        chk("post_rst_status", 64'(rxb[1]), 64'(8'h00));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/systolic_spi_wrap.md
# systolic_spi_wrap

SPI-slave front end plus command controller and matrix-multiply engine for the systolic accelerator. A host loads two N×N signed matrices (A, B) over SPI, starts a multiply, polls status or waits for `irq`, then reads back C = A×B. The block is the chip-level accelerator top; SPI pins are asynchronous to `clk` and are synchronized inside.

## Interface
- `N`, default 2: matrix dimension.
- `DATA_W`, default 16: element width, two's complement; sent as 2 bytes, little-endian.
- `ACC_W`, default 32: result width, two's complement; read as 4 bytes, little-endian.
- `clk`  input  1  system clock; the only clock.
- `rst_n`  input  1  reset; synchronous, active-high (asserted = 1); name kept from the codebase.
- `sclk`  input  1  SPI clock, mode 0, asynchronous to `clk`.
- `mosi`  input  1  SPI data in, MSB first.
- `cs_n`  input  1  SPI chip select, active low.
- `miso`  output  1  SPI data out, MSB first; driven 0 while `cs_n`=1.
- `irq`  output  1  compute-done interrupt, level.

## Operation
- SPI slave (`spi_if`): 2-flop synchronizers on `sclk`, `mosi`, `cs_n`. Sample `mosi` on synchronized `sclk` rising edge; shift `miso` on falling edge. After 8 bits, `rx_valid` pulses for 1 clk with `rx_data`.
- `cs_n` rising mid-byte discards the partial byte and clears the bit counter. Controller state persists across `cs_n` frames, so a command and its data may use separate frames.
- TX shift register loads `tx_data` on the synchronized `cs_n` falling edge and after each completed byte.
- Controller (`spi_ctrl`) states:
  - IDLE=0
  - CMD_DECODE=1
  - LOAD_A=2
  - LOAD_B=3
  - COMPUTING=4
  - READ_C=5
  - STATUS=6
- IDLE: on `rx_valid`, latch byte as command and go to CMD_DECODE. CMD_DECODE lasts 1 clk and clears `data_count`, `element_index`, `byte_index`:
  - 0x10 → LOAD_A
  - 0x20 → LOAD_B
  - 0x30 → COMPUTING
  - 0x40 → READ_C
  - 0x50 → STATUS
  - anything else → IDLE
- LOAD_A / LOAD_B: each byte goes to element `element_index` (row-major). `byte_index` 0 writes bits [7:0]; `byte_index` 1 writes bits [15:8]. When `byte_index` wraps, increment `element_index`. `data_count` counts bytes. After N·N·2 bytes → IDLE.
- COMPUTING: clear `done`. One MAC per clk over (i,j,k), k innermost; N³ clks total. Then write all C, set `done`=1 and `irq`=1, → IDLE. Bytes received while COMPUTING are discarded.
- READ_C: `tx_data` = byte `byte_index` of C[`element_index`]. Advance on each `rx_valid` (host sends dummy bytes). After N·N·4 bytes → IDLE and clear `irq`.
- STATUS: `tx_data` = {6'b0, `done`, `busy`}. Next `rx_valid` → IDLE and clears `irq`.
- Products are full-width signed; accumulation wraps modulo 2^ACC_W.

## Timing
- Reset values:
  - `miso`=0, `irq`=0
  - state IDLE
  - all counters 0
  - A, B, C storage 0
  - `done`=0
- Reset mid-transfer aborts everything; the next byte is treated as a command.
- SCLK high and low phases must each be ≥4 `clk` periods.
- `rx_valid` occurs 3 clk after the 8th `sclk` rising edge (2 sync + 1 edge detect).
- Compute latency: N³+1 clk from entering COMPUTING to `irq`=1.
- A response byte is valid from the frame or byte *after* the command byte.

## Configuration
- `SYSTOLIC_SPI_IRQ_EN` defined: `irq` behaves as above.
- Undefined: `irq` tied 0; the host must poll STATUS.

## Structure
- Shared package `systolic_spi_pkg` holds:
  - state enum
  - command opcodes (CMD_LOAD_A=0x10, CMD_LOAD_B=0x20, CMD_START=0x30, CMD_READ_C=0x40, CMD_STATUS=0x50)
  - default widths
- One sub-module `spi_slave` (instance `spi_if`). Controller, storage and MAC stay in the wrapper (instance name `spi_ctrl` for the controller block scope).

## Test plan
- Send 0x10 → state LOAD_A, `data_count`=0; send 0x01, 0x00 → A[0]=1, `element_index`=1, `byte_index`=0.
- Load A=[1,2;3,4], B=[5,6;7,8]; send 0x30 → `irq`=1 after N³+1 clk; 0x40 plus 16 dummy bytes returns 19,22,43,50 little-endian; `irq`=0.
- Load A with 0xFFFF (−1) and B with 2 everywhere, compute → each C = −4 (0xFFFFFFFC).
- Send 0x50 during COMPUTING → byte read back has `busy`=1; send again after done → 0x02.
- Raise `cs_n` after 5 bits of 0x10, then send 0x20 → controller enters LOAD_B, not LOAD_A.
- Unknown command 0x77 → CMD_DECODE then IDLE, storage unchanged; assert `rst_n` during LOAD_A → IDLE, A cleared.
